dram_responder: RTL and testbench

- Data-memory responder for the MEM stage of the 5-stage RV32 core.
- Accepts one load/store request per handshake and performs byte-lane store masking.
- Returns sign- or zero-extended load data as a one-cycle response pulse, timed so the result lands on the MEM/WB boundary as the synchronous DRAM read data.
- WAIT_CYCLES adds programmable wait states to model slow memory; the block raises a pipeline stall while a request cannot be accepted.

---
 rtl/dram_responder.sv | 165 ++++++++++++++++
 tb/tb_dram_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dram_responder.sv
// dram_responder: MEM-stage data memory with byte-lane store masking,
// sign/zero-extended loads and optional wait states. The response comes
// out of registers in the cycle after the RAM access edge.
module dram_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        stall_o
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int AW = ADDR_WIDTH + 2;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, unsigned_q;
    logic [AW-1:0]     addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        size_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [31:0]       ram [2**ADDR_WIDTH];

    logic              accept;
    logic              enterResp;
    logic              opWe, opUnsigned, opErr;
    logic [AW-1:0]     opAddr;
    logic [31:0]       opWdata, opWdataRep, opWord, opShifted, opLoad;
    logic [1:0]        opSize;
    logic [3:0]        opBe;
    logic              unusedAddrBits;

    assign unusedAddrBits = ^req_addr_i[31:AW];

    assign accept  = req_valid_i && req_ready_o;
    assign stall_o = req_valid_i && !req_ready_o;

    // With no wait states the RAM is accessed at the accept edge straight
    // from the request inputs; otherwise from the fields captured at accept.
    assign enterResp  = (WAIT_CYCLES == 0) ? accept : (state_q == WAIT && cnt_q == 4'd1);
    assign opWe       = (WAIT_CYCLES == 0) ? req_we_i              : we_q;
    assign opAddr     = (WAIT_CYCLES == 0) ? req_addr_i[AW-1:0]    : addr_q;
    assign opWdata    = (WAIT_CYCLES == 0) ? req_wdata_i           : wdata_q;
    assign opSize     = (WAIT_CYCLES == 0) ? req_size_i            : size_q;
    assign opUnsigned = (WAIT_CYCLES == 0) ? req_unsigned_i        : unsigned_q;

    // Next-state logic and ready generation for the request FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                req_ready_o = 1'b1;
                rsp_valid_o = (state_q == RESP);
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Size/alignment decode, byte enables, store replication and load extension.
    always_comb begin
        opErr      = 1'b0;
        opBe       = 4'b0000;
        opWdataRep = opWdata;
        opWord     = ram[opAddr[AW-1:2]];
        opShifted  = opWord >> {opAddr[1:0], 3'b000};
        opLoad     = opWord;
        case (opSize)
            2'b00: begin
                opBe       = 4'b0001 << opAddr[1:0];
                opWdataRep = {4{opWdata[7:0]}};
                opLoad     = opUnsigned ? {24'd0, opShifted[7:0]}
                                        : {{24{opShifted[7]}}, opShifted[7:0]};
            end
            2'b01: begin
                opErr      = opAddr[0];
                opBe       = opAddr[1] ? 4'b1100 : 4'b0011;
                opWdataRep = {2{opWdata[15:0]}};
                opLoad     = opUnsigned ? {16'd0, opShifted[15:0]}
                                        : {{16{opShifted[15]}}, opShifted[15:0]};
            end
            2'b10: begin
                opErr = (opAddr[1:0] != 2'b00);
                opBe  = 4'b1111;
            end
            default: opErr = 1'b1;
        endcase
    end

    // State, captured request fields and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            size_q     <= 2'b00;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q       <= req_we_i;
                unsigned_q <= req_unsigned_i;
                addr_q     <= req_addr_i[AW-1:0];
                wdata_q    <= req_wdata_i;
                size_q     <= req_size_i;
            end
            if (enterResp) begin
                err_q   <= opErr;
                rdata_q <= (opErr || opWe) ? 32'd0 : opLoad;
            end
        end
    end

    // Byte-masked store commit; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && enterResp && opWe && !opErr) begin
            for (int b = 0; b < 4; b++) begin
                if (opBe[b]) begin
                    ram[opAddr[AW-1:2]][b*8 +: 8] <= opWdataRep[b*8 +: 8];
                end
            end
        end
    end

    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dram_responder.sv
// tb_dram_responder: directed vectors on a zero-wait and a two-wait-state
// instance, with a queue-based scoreboard checked by a response monitor.
module tb_dram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        v0 = 0, we0 = 0, un0 = 0;
    logic [31:0] addr0 = 0, wd0 = 0;
    logic [1:0]  sz0 = 0;
    logic        rdy0, rv0, er0, st0;
    logic [31:0] rd0;

    logic        v2 = 0, we2 = 0, un2 = 0;
    logic [31:0] addr2 = 0, wd2 = 0;
    logic [1:0]  sz2 = 0;
    logic        rdy2, rv2, er2, st2;
    logic [31:0] rd2;

    logic [32:0] q0[$];
    logic [32:0] q2[$];

    int checks = 0;
    int fails  = 0;

    dram_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid_i(v0), .req_ready_o(rdy0), .req_we_i(we0),
        .req_addr_i(addr0), .req_wdata_i(wd0), .req_size_i(sz0),
        .req_unsigned_i(un0), .rsp_valid_o(rv0), .rsp_rdata_o(rd0),
        .rsp_err_o(er0), .stall_o(st0)
    );

    dram_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst),
        .req_valid_i(v2), .req_ready_o(rdy2), .req_we_i(we2),
        .req_addr_i(addr2), .req_wdata_i(wd2), .req_size_i(sz2),
        .req_unsigned_i(un2), .rsp_valid_o(rv2), .rsp_rdata_o(rd2),
        .rsp_err_o(er2), .stall_o(st2)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rv0 === 1'b1) begin
            if (q0.size() == 0) begin
                checkOutput("dut0_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                checkOutput("dut0_rsp_err", {31'd0, er0}, {31'd0, e[32]});
                checkOutput("dut0_rsp_rdata", rd0, e[31:0]);
            end
        end
        if (rv2 === 1'b1) begin
            if (q2.size() == 0) begin
                checkOutput("dut2_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = q2.pop_front();
                checkOutput("dut2_rsp_err", {31'd0, er2}, {31'd0, e[32]});
                checkOutput("dut2_rsp_rdata", rd2, e[31:0]);
            end
        end
    end

    // Zero-wait instance: one request per cycle, response pulse in the next cycle.
    task automatic applyStimulus0(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [1:0] sz, input logic un,
                                  input logic expErr, input logic [31:0] expData);
        v0 = 1'b1; we0 = we; addr0 = addr; wd0 = wd; sz0 = sz; un0 = un;
        q0.push_back({expErr, expData});
        checkOutput("dut0_ready", {31'd0, rdy0}, 32'd1);
        checkOutput("dut0_stall", {31'd0, st0}, 32'd0);
        @(posedge clk); #1;
        checkOutput("dut0_rsp_pulse", {31'd0, rv0}, 32'd1);
    endtask

    // Two-wait instance: wait (bounded) for ready, then present for one accept.
    task automatic applyStimulus2(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [1:0] sz, input logic un,
                                  input logic expErr, input logic [31:0] expData);
        int n = 0;
        v2 = 1'b1; we2 = we; addr2 = addr; wd2 = wd; sz2 = sz; un2 = un;
        q2.push_back({expErr, expData});
        while (rdy2 !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) checkOutput("dut2_ready_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        v2 = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        v0 = 1'b0;
        v2 = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        v0 = 1'b0;
        v2 = 1'b0;
        while ((q0.size() != 0 || q2.size() != 0) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) checkOutput("drain_timeout", 32'(q0.size() + q2.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset and idle output state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_ready0", {31'd0, rdy0}, 32'd1);
        checkOutput("rst_valid0", {31'd0, rv0}, 32'd0);
        checkOutput("rst_rdata0", rd0, 32'd0);
        checkOutput("rst_err0", {31'd0, er0}, 32'd0);
        checkOutput("rst_ready2", {31'd0, rdy2}, 32'd1);
        checkOutput("rst_valid2", {31'd0, rv2}, 32'd0);

        // Zero-wait: back-to-back store/load, byte and half lanes, errors, wrap.
        applyStimulus0(1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 0, 32'h0);
        applyStimulus0(0, 32'h10, 32'h0,       2'b10, 0, 0, 32'hDEADBEEF);
        applyStimulus0(1, 32'h20, 32'h0,       2'b10, 0, 0, 32'h0);
        applyStimulus0(1, 32'h30, 32'h0,       2'b10, 0, 0, 32'h0);
        applyStimulus0(1, 32'h21, 32'h80,      2'b00, 0, 0, 32'h0);
        applyStimulus0(0, 32'h21, 32'h0,       2'b00, 0, 0, 32'hFFFFFF80);
        applyStimulus0(0, 32'h21, 32'h0,       2'b00, 1, 0, 32'h00000080);
        applyStimulus0(0, 32'h20, 32'h0,       2'b10, 0, 0, 32'h00008000);
        applyStimulus0(1, 32'h32, 32'hA5A5,    2'b01, 0, 0, 32'h0);
        applyStimulus0(0, 32'h32, 32'h0,       2'b01, 0, 0, 32'hFFFFA5A5);
        applyStimulus0(0, 32'h32, 32'h0,       2'b01, 1, 0, 32'h0000A5A5);
        applyStimulus0(0, 32'h30, 32'h0,       2'b10, 0, 0, 32'hA5A50000);
        applyStimulus0(1, 32'h33, 32'h1234,    2'b01, 0, 1, 32'h0);
        applyStimulus0(0, 32'h22, 32'h0,       2'b10, 0, 1, 32'h0);
        applyStimulus0(1, 32'h30, 32'hFFFFFFFF, 2'b11, 0, 1, 32'h0);
        applyStimulus0(0, 32'h30, 32'h0,       2'b11, 0, 1, 32'h0);
        applyStimulus0(0, 32'h30, 32'h0,       2'b10, 0, 0, 32'hA5A50000);
        applyStimulus0(0, 32'h4010, 32'h0,     2'b10, 0, 0, 32'hDEADBEEF);
        idleCycles(1);
        checkOutput("dut0_pulse_ends", {31'd0, rv0}, 32'd0);
        drain();

        // Two-wait: prime a word, then watch ready/stall while a load waits.
        applyStimulus2(1, 32'h40, 32'h11111111, 2'b10, 0, 0, 32'h0);
        drain();
        v2 = 1'b1; we2 = 1'b0; addr2 = 32'h40; sz2 = 2'b10; un2 = 1'b0;
        q2.push_back({1'b0, 32'h11111111});
        checkOutput("dut2_ready_idle", {31'd0, rdy2}, 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput("dut2_wait_ready", {31'd0, rdy2}, 32'd0);
            checkOutput("dut2_wait_stall", {31'd0, st2}, 32'd1);
            checkOutput("dut2_wait_novalid", {31'd0, rv2}, 32'd0);
            @(posedge clk); #1;
        end
        checkOutput("dut2_resp_valid", {31'd0, rv2}, 32'd1);
        checkOutput("dut2_resp_ready", {31'd0, rdy2}, 32'd1);
        checkOutput("dut2_resp_stall", {31'd0, st2}, 32'd0);
        q2.push_back({1'b0, 32'h11111111});
        @(posedge clk); #1;
        v2 = 1'b0;
        drain();

        // Two-wait: reset while a store waits drops it without a response.
        v2 = 1'b1; we2 = 1'b1; addr2 = 32'h40; wd2 = 32'h12345678; sz2 = 2'b10;
        @(posedge clk); #1;
        v2 = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("dut2_after_rst_ready", {31'd0, rdy2}, 32'd1);
        idleCycles(4);
        applyStimulus2(0, 32'h40, 32'h0, 2'b10, 0, 0, 32'h11111111);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
